// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared-adder arbiter slice.
// A 2W-bit add is run as two chained W-bit passes through one external adder.
package adder_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;
  localparam int ID_W     = $clog2(NREQ_DEF);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LO   = ST_LO,
    HI   = ST_HI,
    RSP  = ST_RSP
  } state_e;

  typedef struct packed {
    logic [2*W_DEF-1:0] a;
    logic [2*W_DEF-1:0] b;
    logic               cin;
    logic               wide;
    logic [ID_W-1:0]    id;
  } op_t;

endpackage

// File: rtl/adder_share_arb_props.sv
// Property checker for adder_share_arb: result equals a reference sum of the
// accepted op, accepts are one-hot and only happen with no op in flight.
module adder_share_arb_props
  import adder_share_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  input logic [NREQ_DEF-1:0]       req_ready,
  input logic [NREQ_DEF*2*W_DEF-1:0] req_a,
  input logic [NREQ_DEF*2*W_DEF-1:0] req_b,
  input logic [NREQ_DEF-1:0]       req_cin,
  input logic [NREQ_DEF-1:0]       req_wide,
  input logic                      rsp_valid,
  input logic                      rsp_ready,
  input logic [ID_W-1:0]           rsp_id,
  input logic [2*W_DEF-1:0]        rsp_sum,
  input logic                      rsp_cout
);

  localparam int SW = 2*W_DEF + 1;
  localparam int NW = W_DEF + 1;

  op_t           op;
  logic          in_flight;
  logic [SW-1:0] ref_val;
  logic [NW-1:0] narrow_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op        <= '0;
      in_flight <= 1'b0;
    end else if (req_ready != '0) begin
      for (int i = 0; i < NREQ_DEF; i++) begin
        if (req_ready[i]) begin
          op.a    <= req_a[i*2*W_DEF +: 2*W_DEF];
          op.b    <= req_b[i*2*W_DEF +: 2*W_DEF];
          op.cin  <= req_cin[i];
          op.wide <= req_wide[i];
          op.id   <= ID_W'(i);
        end
      end
      in_flight <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      in_flight <= 1'b0;
    end
  end

  always_comb begin
    narrow_sum = {1'b0, op.a[W_DEF-1:0]} + {1'b0, op.b[W_DEF-1:0]} + NW'(op.cin);
    if (op.wide) ref_val = {1'b0, op.a} + {1'b0, op.b} + SW'(op.cin);
    else         ref_val = {narrow_sum[W_DEF], {W_DEF{1'b0}}, narrow_sum[W_DEF-1:0]};
  end

  a_sum: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> ({rsp_cout, rsp_sum} == ref_val && rsp_id == op.id));
  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_idle_only: assert property (@(posedge clk) disable iff (!rst)
    (req_ready != '0) |-> !in_flight);

endmodule

// File: rtl/adder_share_arb_rr_arb.sv
// Round-robin arbiter: grants the first set request at or after ptr, wrapping.
// Produces both a one-hot grant and its encoded index.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one external W-bit adder among NREQ requesters; wide ops take a low
// pass then a high pass using the carry captured from the low pass.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*2*W-1:0]       req_a,
  input  logic [NREQ*2*W-1:0]       req_b,
  input  logic [NREQ-1:0]           req_cin,
  input  logic [NREQ-1:0]           req_wide,
  output logic [W-1:0]              add_a,
  output logic [W-1:0]              add_b,
  output logic                      add_cin,
  input  logic [W-1:0]              add_s,
  input  logic                      add_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*W-1:0]            rsp_sum,
  output logic                      rsp_cout
);

  localparam int IW = $clog2(NREQ);

  logic [1:0]     state;
  logic [IW-1:0]  ptr;
  logic [2*W-1:0] op_a;
  logic [2*W-1:0] op_b;
  logic           op_cin;
  logic           op_wide;
  logic [IW-1:0]  op_id;
  logic [W-1:0]   sum_lo;
  logic [W-1:0]   sum_hi;
  logic           carry;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_any;
  logic [2*W-1:0]  sel_a;
  logic [2*W-1:0]  sel_b;

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign sel_a     = req_a[int'(gnt_id)*2*W +: 2*W];
  assign sel_b     = req_b[int'(gnt_id)*2*W +: 2*W];
  assign req_ready = (state == ST_IDLE) ? gnt : '0;

  assign rsp_valid = (state == ST_RSP);
  assign rsp_id    = op_id;
  assign rsp_sum   = {sum_hi, sum_lo};
  assign rsp_cout  = carry;

  // The adder is only driven during the two compute passes.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      ST_LO: begin
        add_a   = op_a[W-1:0];
        add_b   = op_b[W-1:0];
        add_cin = op_cin;
      end
      ST_HI: begin
        add_a   = op_a[2*W-1:W];
        add_b   = op_b[2*W-1:W];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      op_wide <= 1'b0;
      op_id   <= '0;
      sum_lo  <= '0;
      sum_hi  <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_cin  <= req_cin[gnt_id];
            op_wide <= req_wide[gnt_id];
            op_id   <= gnt_id;
            ptr     <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            // Narrow results must report a zero upper half.
            sum_hi  <= '0;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          sum_lo <= add_s;
          carry  <= add_cout;
          state  <= op_wide ? ST_HI : ST_RSP;
        end
        ST_HI: begin
          sum_hi <= add_s;
          carry  <= add_cout;
          state  <= ST_RSP;
        end
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed, table-driven bench for adder_share_arb with a behavioural adder
// standing in for the external cond_sum32.
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*2*W-1:0] req_a;
  logic [NREQ*2*W-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_wide;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic               add_cin;
  logic [W-1:0]       add_s;
  logic               add_cout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [2*W-1:0]     rsp_sum;
  logic               rsp_cout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        wide;
    logic [63:0] sum;
    logic        cout;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  adder_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  adder_share_arb_props u_props (
    .clk       (clk),
    .rst       (rst),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_wide  (req_wide),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic wide);
    req_a[id*64 +: 64] = a;
    req_b[id*64 +: 64] = b;
    req_cin[id]        = cin;
    req_wide[id]       = wide;
    req_valid[id]      = 1'b1;
  endtask

  task automatic waitGrant(output logic [3:0] g);
    int n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    g = req_ready;
  endtask

  // Called at the sample point of the accept cycle; counts cycles to rsp_valid.
  task automatic finishOp(input int id, input logic [63:0] sum, input logic cout, input int lat);
    int n = 1;
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("latency", n, lat);
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_id", rsp_id, id);
    checkOutput("rsp_sum", rsp_sum, sum);
    checkOutput("rsp_cout", rsp_cout, cout);
  endtask

  task automatic runOp(input vec_t v);
    logic [3:0] g;
    @(negedge clk);
    applyStimulus(v.id, v.a, v.b, v.cin, v.wide);
    #1;
    waitGrant(g);
    checkOutput("grant", g, 4'b1 << v.id);
    finishOp(v.id, v.sum, v.cout, v.lat);
    @(negedge clk); #1;
    checkOutput("rsp_done", rsp_valid, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] g;
    int order[6];
    int seen;

    vecs[0] = '{0, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 2};
    vecs[1] = '{2, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_0002_0000_0000, 1'b0, 3};
    vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3};
    vecs[3] = '{3, 64'h1234_5678, 64'hFFFF_0000_1111_1111, 1'b1, 1'b0, 64'h2345_678A, 1'b0, 2};
    vecs[4] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h0, 1'b1, 3};
    vecs[5] = '{2, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b0, 64'h1, 1'b1, 2};
    order = '{0, 1, 2, 3, 0, 2};

    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_wide  = '0;
    rsp_ready = 1'b1;

    @(negedge clk); #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_add", {add_a, add_b, add_cin}, 0);
    checkOutput("reset_rsp_data", {rsp_id, rsp_cout, rsp_sum}, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) runOp(vecs[i]);

    $display("[TB] round robin from reset");
    pulseReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 64'(i), 64'(i), 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 6; k++) begin
      waitGrant(g);
      checkOutput("rr_grant", g, 4'b1 << order[k]);
      finishOp(order[k], 64'(2 * order[k]), 1'b0, 2);
      if (k == 3) begin
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
      end
      @(negedge clk); #1;
    end
    checkOutput("rr_idle", req_ready, 0);

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(3, 64'h5, 64'h7, 1'b0, 1'b0);
    #1;
    waitGrant(g);
    checkOutput("bp_grant", g, 4'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    applyStimulus(0, 64'h1, 64'h2, 1'b0, 1'b0);
    @(negedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", rsp_valid, 1);
      checkOutput("bp_sum", {rsp_id, rsp_sum}, {2'd3, 64'hC});
      checkOutput("bp_no_grant", req_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("bp_released", rsp_valid, 0);
    checkOutput("bp_next_grant", req_ready, 4'b0001);
    finishOp(0, 64'h3, 1'b0, 2);
    @(negedge clk); #1;

    $display("[TB] reset during high pass");
    applyStimulus(2, 64'h1234_5678_0000_0001, 64'h0000_0001_0000_0002, 1'b0, 1'b1);
    #1;
    waitGrant(g);
    checkOutput("rst_grant", g, 4'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk); #1;
    checkOutput("hi_pass_add", {add_a, add_b, add_cin}, {32'h1234_5678, 32'h1, 1'b0});
    rst = 1'b0;
    #1;
    checkOutput("midrst_add", {add_a, add_b, add_cin}, 0);
    checkOutput("midrst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
    checkOutput("midrst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", seen, 0);
    runOp('{1, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 2});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
